dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the core's load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake and applies a configurable number of wait states.
- Performs byte/half/word access with RISC-V funct3 size/sign semantics, then returns a response over a second valid/ready handshake.
- Replaces the zero-latency DMEM so the core can be exercised against realistic, stalling memory.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic RSP_ERR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and size/sign extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  // Half accesses only look at addr[1], word accesses at neither: misaligned low bits are masked here.
  always_comb begin
    bsel  = 8'(rword >> {addr, 3'b000});
    hsel  = 16'(rword >> {addr[1], 4'b0000});
    be    = 4'b0000;
    wword = 32'h0;
    rdata = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr;
        wword = {4{wdata[7:0]}};
        rdata = funct3[2] ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
      end
      F3_H, F3_HU: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = funct3[2] ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
      end
      F3_W: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Stalling data-memory responder with valid/ready request and response channels.
// Optional alignment faulting is enabled with DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  dmem_req_t        req_q, req_n, req_in, cur;
  logic             ready_n, valid_n, err_n;
  logic [31:0]      rdata_n;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off;
  logic [IDX_W-1:0] idx;
  logic [31:0] word;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] lval;
  logic        acc_err;
  logic        enter_resp;
  logic        commit;

  assign req_in.addr   = req_addr;
  assign req_in.we     = req_we;
  assign req_in.funct3 = req_funct3;
  assign req_in.wdata  = req_wdata;

  // With zero latency the access happens on the accept edge, straight from the inputs.
  assign cur  = (state == ST_IDLE) ? req_in : req_q;
  assign off  = cur.addr - BASE_ADDR;
  assign idx  = off[IDX_W+1:2];
  assign word = mem[idx];

  dmem_lane_align u_lane (
    .funct3 (cur.funct3),
    .addr   (cur.addr[1:0]),
    .wdata  (cur.wdata),
    .rword  (word),
    .be     (be),
    .wword  (wword),
    .rdata  (lval)
  );

  // Range, encoding and (optionally) alignment faults; an address below the base wraps high.
  always_comb begin
    acc_err = ({1'b0, off} >= SPAN);
    case (cur.funct3)
      F3_B, F3_H, F3_W: ;
      F3_BU, F3_HU: if (cur.we) acc_err = 1'b1;
      default: acc_err = 1'b1;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    if ((cur.funct3 == F3_H || cur.funct3 == F3_HU) && cur.addr[0]) acc_err = 1'b1;
    if (cur.funct3 == F3_W && cur.addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      req_q     <= req_n;
      req_ready <= ready_n;
      rsp_valid <= valid_n;
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    req_n      = req_q;
    rdata_n    = rsp_rdata;
    err_n      = rsp_err;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          req_n = req_in;
          if (LATENCY == 0) begin
            enter_resp = 1'b1;
            state_n    = ST_RESP;
          end else begin
            cnt_n   = CNT_W'(LATENCY - 1);
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          enter_resp = 1'b1;
          state_n    = ST_RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    ready_n = (state_n == ST_IDLE);
    valid_n = (state_n == ST_RESP);
    if (enter_resp) begin
      err_n   = acc_err ? RSP_ERR : ~RSP_ERR;
      rdata_n = (acc_err || cur.we) ? 32'h0 : lval;
    end else if (state == ST_RESP && rsp_ready) begin
      err_n   = 1'b0;
      rdata_n = 32'h0;
    end
  end

  assign commit = enter_resp && cur.we && !acc_err && !rst;

  // Array has no reset; stores land only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-level reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned WIN   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] mdl [WIN];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decides fault/result from the access rules and updates the model words.
  function automatic void model_access(input logic [31:0] a, input logic we, input logic [2:0] f3,
                                       input logic [31:0] wd, output logic [31:0] d, output logic e);
    longint unsigned off;
    int unsigned wi, lane, val;
    logic [31:0] w;
    d = 32'h0;
    e = 1'b0;
    off = longint'(a) - longint'(BASE);
    if (a < BASE || off >= longint'(DEPTH) * 4) e = 1'b1;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) e = 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) e = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) e = 1'b1;
    if (f3 == 3'd2 && (a % 4) != 0) e = 1'b1;
`endif
    if (e) return;
    wi   = int'(off / 4);
    lane = a % 4;
    w    = mdl[wi];
    if (we) begin
      if (f3 == 3'd0) w[8*lane +: 8] = wd[7:0];
      else if (f3 == 3'd1) w[16*(lane/2) +: 16] = wd[15:0];
      else w = wd;
      mdl[wi] = w;
    end else begin
      if (f3 == 3'd0 || f3 == 3'd4) begin
        val = (w >> (8 * lane)) % 256;
        d = (f3 == 3'd0 && val >= 128) ? 32'(val + 32'hFFFF_FF00) : 32'(val);
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        val = (w >> (16 * (lane / 2))) % 65536;
        d = (f3 == 3'd1 && val >= 32768) ? 32'(val + 32'hFFFF_0000) : 32'(val);
      end else begin
        d = w;
      end
    end
  endfunction

  task automatic txn(input logic [31:0] a, input logic we, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold, input logic early_ready);
    logic [31:0] exp_d, held;
    logic exp_e;
    int n;
    model_access(a, we, f3, wd, exp_d, exp_e);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = we; req_funct3 = f3; req_wdata = wd;
    rsp_ready = early_ready;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_we = ~we; req_funct3 = 3'(~f3); req_wdata = $urandom;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", 32'(n), 32'(LAT + 1));
    check("rsp_rdata", rsp_rdata, exp_d);
    check("rsp_err", 32'(rsp_err), 32'(exp_e));
    check("req_ready_in_resp", 32'(req_ready), 32'd0);
    held = rsp_rdata;
    if (!early_ready) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_rdata", rsp_rdata, held);
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
    check("valid_after_hs", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [2:0] f3;
    logic we;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_funct3 = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < int'(WIN); i++) txn(32'(i * 4), 1'b1, 3'd2, $urandom, 0, 1'b0);

    txn(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 0, 1'b0);
    txn(32'h10, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    txn(32'h13, 1'b0, 3'd0, 32'h0, 0, 1'b0);
    txn(32'h13, 1'b0, 3'd4, 32'h0, 0, 1'b0);
    txn(32'h12, 1'b0, 3'd1, 32'h0, 0, 1'b0);
    txn(32'h10, 1'b0, 3'd5, 32'h0, 0, 1'b0);
    txn(32'h11, 1'b1, 3'd0, 32'h55, 0, 1'b0);
    txn(32'h10, 1'b0, 3'd2, 32'h0, 5, 1'b0);
    check("sb_lane1_model", mdl[4], 32'hDEAD55EF);
    txn(32'h1000, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    txn(32'h1000, 1'b1, 3'd2, 32'hA5A5A5A5, 0, 1'b0);
    txn(32'h0, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    txn(32'h22, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    txn(32'h20, 1'b1, 3'd5, 32'h1234, 0, 1'b1);

    // Reset during WAIT must drop the pending store and produce no response.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h20; req_we = 1'b1; req_funct3 = 3'd2; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    txn(32'h20, 1'b0, 3'd2, 32'h0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, WIN * 4 - 1));
      else a = $urandom | 32'h0000_1000;
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      txn(a, we, f3, wd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
